// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, single-outstanding imem requests, output register to decode
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   imem_req_o           fetch request; may drop before grant
//   imem_addr_o[31:0]    word-aligned fetch address (next fetch PC)
//   imem_gnt_i           request accepted this cycle (only meaningful while req=1)
//   imem_rvalid_i        read data valid, exactly one per grant
//   imem_rdata_i[31:0]   read data
//   redirect_i           single-cycle PC redirect from a later stage
//   redirect_pc_i[31:0]  redirect target, low two bits ignored
//   instr_valid_o        output register holds a valid instruction
//   instr_ready_i        decode consumes instr_o this cycle
//   instr_o[31:0]        fetched instruction word
//   pc_o[31:0]           PC of instr_o

module fetch_stage #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        discard_q, discard_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        req;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_REQ;
            addr_q        <= BOOT_PC;
            pend_pc_q     <= 32'h0;
            discard_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            pc_q          <= 32'h0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            pend_pc_q     <= pend_pc_d;
            discard_q     <= discard_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        pend_pc_d     = pend_pc_q;
        discard_d     = discard_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_d          = pc_q;

        // Only request when the output register is empty or draining this
        // cycle, so the single outstanding response always has a free slot.
        // Reset gates the request so it is low while rst_ni is asserted.
        req = rst_ni && (state_q == ST_REQ) && !redirect_i &&
              (!instr_valid_q || instr_ready_i);

        if (instr_valid_q && instr_ready_i) begin
            instr_valid_d = 1'b0;
        end

        if (redirect_i) begin
            addr_d        = {redirect_pc_i[31:2], 2'b00};
            instr_valid_d = 1'b0;
            if (state_q == ST_WAIT) begin
                if (imem_rvalid_i) begin
                    // Stale response arrives with the redirect: drop it now.
                    discard_d = 1'b0;
                    state_d   = ST_REQ;
                end else begin
                    // Response still in flight: swallow it when it lands.
                    discard_d = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    // rvalid here is a protocol error and is ignored.
                    if (req && imem_gnt_i) begin
                        pend_pc_d = addr_q;
                        addr_d    = addr_q + 32'd4;
                        state_d   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            instr_d       = imem_rdata_i;
                            pc_d          = pend_pc_q;
                            instr_valid_d = 1'b1;
                        end
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the riscv_cpu core, directly upstream of decode.
- Holds the fetch PC and issues word requests to instruction memory, one outstanding at a time.
- Buffers the returned word with its PC in an output register and hands it to decode over a valid/ready handshake.
- Accepts single-cycle redirects (branch/jump) from later stages and squashes stale fetches.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC after reset; bits [1:0] ignored (treated as 0).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  word-aligned fetch address; bits [1:0] always 0.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  32  read data.
- redirect_i  input  1  single-cycle PC redirect.
- redirect_pc_i  input  32  redirect target; bits [1:0] forced to 0.
- instr_valid_o  output  1  output register holds a valid instruction.
- instr_ready_i  input  1  decode consumes the instruction this cycle.
- instr_o  output  32  fetched instruction word.
- pc_o  output  32  PC of instr_o.

Behaviour:
- Memory protocol is SRAM-arbiter style:
  - imem_req_o/imem_addr_o may change or drop before gnt.
  - gnt only counts while req=1.
  - Exactly one rvalid follows each gnt, at least 1 cycle later.
- Registers: state_q {REQ, WAIT}, addr_q (next fetch address), pend_pc_q (PC of the outstanding request), discard_q, plus the output register {instr_valid_o, instr_o, pc_o}.
- Reset (async, rst_ni=0):
  - state=REQ, addr_q=BOOT_ADDR&~3, pend_pc_q=0, discard_q=0.
  - instr_valid_o=0, instr_o=0, pc_o=0, imem_req_o=0.
  - Memory is reset alongside, so no response is pending after reset.
- imem_addr_o=addr_q at all times.
- REQ state:
  - imem_req_o = !redirect_i && (!instr_valid_o || instr_ready_i). Request only when the output register is empty or draining, so a returning rvalid always finds it free.
  - On req&&gnt: pend_pc_q<=addr_q; addr_q<=addr_q+4 (wraps mod 2^32); go to WAIT.
  - No gnt: stay in REQ.
- WAIT state:
  - imem_req_o=0.
  - On rvalid with discard_q=0: instr_o<=imem_rdata_i, pc_o<=pend_pc_q, instr_valid_o<=1; go to REQ.
  - On rvalid with discard_q=1: drop the data, discard_q<=0; go to REQ.
- Output handshake:
  - instr_valid_o && instr_ready_i clears instr_valid_o next cycle, unless reloaded that same cycle.
  - While valid and not ready, instr_o and pc_o are held stable.
- Redirect (redirect_i=1) has highest priority in any state:
  - addr_q<=redirect_pc_i&~3.
  - instr_valid_o<=0, regardless of instr_ready_i.
  - No request is issued that cycle.
  - If in WAIT without rvalid: discard_q<=1; stay in WAIT.
  - If in WAIT with rvalid that cycle: drop the response, discard_q<=0; go to REQ.
  - If in REQ: stay in REQ.
  - Redirect while discard_q=1 and still waiting: keep discard_q=1 and take the new target.
- Latency and throughput:
  - First req is in the first cycle after reset release.
  - With gnt same cycle and rvalid the next cycle, instr_valid_o rises 2 cycles after req.
  - Peak rate is 1 instruction per 2 cycles.
- Error conditions:
  - rvalid in REQ state is a protocol error; the block ignores it.
  - gnt without req is ignored.

Test Plan:
- Reset release, BOOT_ADDR=32'h80, gnt always, rvalid 1 cycle after gnt, ready=1 -> addresses 0x80, 0x84, 0x88; pc_o/instr_o pairs match; instr_valid_o pulses every 2nd cycle.
- Decode stalls (ready=0) with valid instruction at PC 0x84 -> imem_req_o stays 0; instr_o/pc_o held; when ready=1, the request to 0x88 issues that same cycle.
- Redirect to 0x200 while in WAIT for 0x84 -> 0x84 response dropped, valid stays 0; next request addr=0x200; pc_o=0x200 on delivery.
- Redirect to 0x300 in the same cycle as rvalid -> data dropped; next cycle req to 0x300; no spurious valid.
- gnt delayed 3 cycles, then redirect_pc_i=0x403 during REQ -> addr switches to 0x400; only 0x400 is fetched and delivered.
- Assert rst_ni=0 mid-WAIT with valid output -> same cycle, instr_valid_o=0 and imem_req_o=0; after release, fetch restarts at BOOT_ADDR.
